inv_sub_bytes_iter: RTL and testbench

Iterative inverse byte-substitution engine for the AES decryption datapath. It applies the inverse S-box to all 16 bytes of a 128-bit state and processes `BYTES_PER_CYCLE` bytes per clock, trading latency for area against a fully parallel 16-lookup array. It sits in the inverse-round pipeline after InvShiftRows and before AddRoundKey, and uses a valid/ready handshake on both sides.

---
 rtl/aes_pkg.sv | 18 +
 rtl/inv_sub_bytes_iter_inv_sbox.sv | 29 ++
 rtl/inv_sub_bytes_iter.sv | 127 ++++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and the inverse-substitution FSM state encoding.
package aes_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    ISB_IDLE = 2'd0,
    ISB_RUN  = 2'd1,
    ISB_DONE = 2'd2
  } isb_state_t;

  // Lookups per cycle must divide the 16-byte state into equal power-of-two groups.
  function automatic bit bpc_is_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
  endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// Combinational 8-bit AES inverse S-box (FIPS-197 table).
module InvSBox (
  input  logic [7:0] iData,
  output logic [7:0] oData
);

  // Entry 0 sits in the most significant byte of the literal.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign oData = INV_SBOX[iData];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of the state per clock,
// with valid/ready handshakes on input and output and no overlap between states.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [AES_STATE_W-1:0] iData,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [AES_STATE_W-1:0] oData,
  output logic                   oBusy
);

  localparam int N     = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!bpc_is_legal(BYTES_PER_CYCLE)) begin : g_bad_bpc
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  isb_state_t                        state_p0;
  logic [CNT_W-1:0]                  grp_cnt;
  logic [CNT_W-1:0]                  grp_cnt_next;
  logic                              grp_last;
  logic [AES_NUM_BYTES-1:0][7:0]     work_p0;
  logic [AES_NUM_BYTES-1:0][7:0]     work_next;
  logic [AES_NUM_BYTES-1:0]          byte_we;
  logic [7:0]                        sbox_in  [BYTES_PER_CYCLE];
  logic [7:0]                        sbox_out [BYTES_PER_CYCLE];
  logic                              ready_q;
  logic                              vld_p0;
  logic                              busy_q;

  assign grp_last     = (grp_cnt == CNT_W'(N - 1));
  assign grp_cnt_next = grp_last ? '0 : grp_cnt + CNT_W'(1);

  // Group multiplexer: route the current group's bytes to the S-box lanes.
  always_comb begin : group_mux
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      sbox_in[j] = work_p0[j];
    end
    for (int g = 1; g < N; g++) begin
      if (grp_cnt == CNT_W'(g)) begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          sbox_in[j] = work_p0[g * BYTES_PER_CYCLE + j];
        end
      end
    end
  end

  for (genvar gj = 0; gj < BYTES_PER_CYCLE; gj++) begin : g_lane
    InvSBox u_inv_sbox (
      .iData (sbox_in[gj]),
      .oData (sbox_out[gj])
    );
  end

  // Byte write-enable decode: only the active group takes lane results while running.
  always_comb begin : byte_write
    byte_we   = '0;
    work_next = work_p0;
    for (int k = 0; k < AES_NUM_BYTES; k++) begin
      byte_we[k] = (state_p0 == ISB_RUN) &&
                   (grp_cnt == CNT_W'(k / BYTES_PER_CYCLE));
      if (byte_we[k]) begin
        work_next[k] = sbox_out[k % BYTES_PER_CYCLE];
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_p0 <= ISB_IDLE;
      grp_cnt  <= '0;
      work_p0  <= '0;
      ready_q  <= 1'b1;
      vld_p0   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_p0)
        ISB_IDLE: begin
          if (iValid && ready_q) begin
            work_p0  <= iData;
            grp_cnt  <= '0;
            state_p0 <= ISB_RUN;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ISB_RUN: begin
          work_p0 <= work_next;
          grp_cnt <= grp_cnt_next;
          if (grp_last) begin
            state_p0 <= ISB_DONE;
            vld_p0   <= 1'b1;
          end
        end
        ISB_DONE: begin
          if (iReady) begin
            state_p0 <= ISB_IDLE;
            vld_p0   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_p0 <= ISB_IDLE;
          grp_cnt  <= '0;
          ready_q  <= 1'b1;
          vld_p0   <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign oReady = ready_q;
  assign oValid = vld_p0;
  assign oBusy  = busy_q;
  assign oData  = work_p0;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: one instance per legal BYTES_PER_CYCLE, scoreboarded
// expectations, round trips through a forward S-box model.
module tb_inv_sub_bytes_iter;

  localparam int NDUT = 5;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NDUT-1:0]   valid_in;
  logic [NDUT-1:0]   ready_in;
  wire  [NDUT-1:0]   ready_out;
  wire  [NDUT-1:0]   valid_out;
  wire  [NDUT-1:0]   busy_out;
  logic [127:0]      data_in  [NDUT];
  wire  [127:0]      data_out [NDUT];
  logic [127:0]      exp_q [$];
  int                vec_cnt = 0;
  int                err_cnt = 0;
  int                cyc = 0;

  always #5 clk = ~clk;

  // Instance gi runs with BYTES_PER_CYCLE = 2**gi, so N = 16 >> gi.
  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << gi)) u_dut (
      .iClk   (clk),
      .iRst   (rst),
      .iValid (valid_in[gi]),
      .oReady (ready_out[gi]),
      .iData  (data_in[gi]),
      .oValid (valid_out[gi]),
      .iReady (ready_in[gi]),
      .oData  (data_out[gi]),
      .oBusy  (busy_out[gi])
    );
  end

  function automatic logic [127:0] fwd_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = SBOX[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("rdy_vld_excl", 128'(ready_out & valid_out), 128'h0);
  endtask

  task automatic wait_ready(input int sel, input string tag);
    int n = 0;
    while (!ready_out[sel] && n < 64) begin step(); n++; end
    check({tag, "_rdy"}, 128'(ready_out[sel]), 128'h1);
  endtask

  task automatic wait_valid(input int sel, input string tag);
    int n = 0;
    while (!valid_out[sel] && n < 64) begin step(); n++; end
    check({tag, "_lat"}, 128'(n), 128'(16 >> sel));
  endtask

  task automatic accept(input int sel, input logic [127:0] din);
    data_in[sel]  = din;
    valid_in[sel] = 1'b1;
    step();
    valid_in[sel] = 1'b0;
    data_in[sel]  = rand_state();
  endtask

  task automatic pop_check(input int sel, input string tag);
    logic [127:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = ~data_out[sel];
    check({tag, "_data"}, data_out[sel], e);
  endtask

  // Full transaction with iReady held high.
  task automatic xfer(input int sel, input logic [127:0] din, input logic [127:0] exp,
                      input string tag);
    exp_q.push_back(exp);
    wait_ready(sel, tag);
    accept(sel, din);
    wait_valid(sel, tag);
    pop_check(sel, tag);
    step();
    check({tag, "_vld_drop"}, 128'(valid_out[sel]), 128'h0);
  endtask

  initial begin
    logic [127:0] din, exp, r, held;
    int           rises [3];
    int           nr, guard;
    bit           prev;

    valid_in = '0;
    ready_in = '1;
    for (int i = 0; i < NDUT; i++) data_in[i] = '0;

    repeat (2) step();
    for (int s = 0; s < NDUT; s++) begin
      check("rst_ready", 128'(ready_out[s]), 128'h1);
      check("rst_valid", 128'(valid_out[s]), 128'h0);
      check("rst_busy",  128'(busy_out[s]),  128'h0);
      check("rst_data",  data_out[s],        128'h0);
    end
    rst = 1'b0;

    // Reset asserted mid-RUN on the B=4 instance discards the state.
    accept(2, {16{8'h63}});
    step();
    check("run_busy", 128'(busy_out[2]), 128'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 128'(valid_out[2]), 128'h0);
    check("async_rst_ready", 128'(ready_out[2]), 128'h1);
    check("async_rst_busy",  128'(busy_out[2]),  128'h0);
    check("async_rst_data",  data_out[2],        128'h0);
    step();
    check("rst_next_valid", 128'(valid_out[2]), 128'h0);
    check("rst_next_data",  data_out[2],        128'h0);
    rst = 1'b0;

    xfer(2, {16{8'h63}}, {16{8'h00}}, "all63");
    xfer(2, {16{8'h16}}, {16{8'hff}}, "all16");
    xfer(2, {16{8'h00}}, {16{8'h52}}, "all00");

    // One distinguished byte per position exposes group ordering on every width.
    for (int s = 0; s < NDUT; s++) begin
      for (int k = 0; k < 16; k++) begin
        din = {16{8'h63}};
        din[8*k +: 8] = 8'h7c;
        exp = '0;
        exp[8*k +: 8] = 8'h01;
        xfer(s, din, exp, "byte_pos");
      end
    end

    for (int s = 0; s < NDUT; s++) begin
      for (int t = 0; t < 200; t++) begin
        r = rand_state();
        xfer(s, fwd_sub(r), r, "round_trip");
      end
    end

    // Backpressure: output must hold for 10 cycles while stray iValid pulses are ignored.
    ready_in[2] = 1'b0;
    r = rand_state();
    exp_q.push_back(r);
    wait_ready(2, "bp");
    accept(2, fwd_sub(r));
    wait_valid(2, "bp");
    held = data_out[2];
    pop_check(2, "bp");
    for (int i = 0; i < 10; i++) begin
      valid_in[2] = i[0];
      data_in[2]  = rand_state();
      step();
      check("bp_valid_hold", 128'(valid_out[2]), 128'h1);
      check("bp_ready_low",  128'(ready_out[2]), 128'h0);
      check("bp_data_hold",  data_out[2], held);
    end
    valid_in[2] = 1'b0;
    ready_in[2] = 1'b1;
    step();
    check("bp_release_valid", 128'(valid_out[2]), 128'h0);
    check("bp_release_busy",  128'(busy_out[2]),  128'h0);
    step();
    check("bp_no_accept", 128'(busy_out[2]), 128'h0);

    // iValid and iReady together in DONE: output leaves, input waits one IDLE cycle.
    ready_in[2] = 1'b0;
    r = rand_state();
    exp_q.push_back(r);
    wait_ready(2, "sim");
    accept(2, fwd_sub(r));
    wait_valid(2, "sim");
    pop_check(2, "sim");
    r = rand_state();
    exp_q.push_back(r);
    data_in[2]  = fwd_sub(r);
    valid_in[2] = 1'b1;
    ready_in[2] = 1'b1;
    step();
    check("sim_out_gone", 128'(valid_out[2]), 128'h0);
    check("sim_not_taken", 128'(busy_out[2]), 128'h0);
    check("sim_ready_up", 128'(ready_out[2]), 128'h1);
    step();
    valid_in[2] = 1'b0;
    check("sim_taken_next", 128'(busy_out[2]), 128'h1);
    wait_valid(2, "sim2");
    pop_check(2, "sim2");
    step();

    // Throughput with iValid and iReady both held high: one state per N+2 cycles.
    for (int s = 0; s < NDUT; s += 2) begin
      wait_ready(s, "thr");
      data_in[s]  = rand_state();
      valid_in[s] = 1'b1;
      nr = 0;
      guard = 0;
      prev = busy_out[s];
      while (nr < 3 && guard < 200) begin
        step();
        guard++;
        if (busy_out[s] && !prev) begin
          rises[nr] = cyc;
          nr++;
        end
        prev = busy_out[s];
      end
      valid_in[s] = 1'b0;
      check("thr_rises", 128'(nr), 128'h3);
      if (nr == 3) begin
        check("thr_period_a", 128'(rises[1] - rises[0]), 128'((16 >> s) + 2));
        check("thr_period_b", 128'(rises[2] - rises[1]), 128'((16 >> s) + 2));
      end
      wait_ready(s, "thr_drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
